// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: active-low column strobe, 2-FF row synchronizer,
// full-scan debounce FSM. Optional BCD entry shift register under `ENTRY_REG_EN`.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 100_000,
  parameter int unsigned DEBOUNCE_SCANS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic [15:0] entry
);

  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CntW = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(DEBOUNCE_SCANS);
  // Scan results are {none, code}; bit 4 set means no single key was seen.
  localparam logic [4:0]      ResNone = 5'h10;

  typedef enum logic [1:0] {
    StIdle,
    StPressDb,
    StPressed,
    StReleaseDb
  } state_e;

  logic [3:0]      row_s1_q, row_s2_q;
  logic [DivW-1:0] div_q, div_d;
  logic [1:0]      col_idx_q, col_idx_d;
  logic [3:0]      col_q, col_d;
  logic [15:0]     snap_q, snap_d;
  logic [4:0]      prev_q, prev_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  state_e          state_q, state_d;
  logic [3:0]      key_code_q, key_code_d;
  logic            valid_q, valid_d;
  logic            held_q, held_d;

  logic            col_end;
  logic            scan_end;
  logic            accept;
  logic [4:0]      low_cnt;
  logic [3:0]      hit_idx;
  logic [4:0]      result;
  logic [3:0]      sidx;

  // Snapshot bit index is {row, col}.
  function automatic logic [3:0] code_of(input logic [3:0] idx);
    logic [3:0] code;
    case (idx)
      4'd0:    code = 4'h1;
      4'd1:    code = 4'h2;
      4'd2:    code = 4'h3;
      4'd3:    code = 4'hA;
      4'd4:    code = 4'h4;
      4'd5:    code = 4'h5;
      4'd6:    code = 4'h6;
      4'd7:    code = 4'hB;
      4'd8:    code = 4'h7;
      4'd9:    code = 4'h8;
      4'd10:   code = 4'h9;
      4'd11:   code = 4'hC;
      4'd12:   code = 4'hE;
      4'd13:   code = 4'h0;
      4'd14:   code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_s1_q <= 4'hF;
      row_s2_q <= 4'hF;
    end else begin
      row_s1_q <= row_in;
      row_s2_q <= row_s1_q;
    end
  end

  // Column timing and row sampling.
  always_comb begin
    col_end   = (div_q == DivLast);
    scan_end  = col_end && (col_idx_q == 2'd3);
    div_d     = col_end ? '0 : div_q + DivW'(1);
    col_idx_d = col_end ? col_idx_q + 2'd1 : col_idx_q;
    col_d     = col_end ? {col_q[2:0], col_q[3]} : col_q;
    snap_d    = snap_q;
    sidx      = '0;
    if (col_end) begin
      for (int r = 0; r < 4; r++) begin
        sidx         = {2'(r), col_idx_q};
        snap_d[sidx] = row_s2_q[r];
      end
    end
  end

  // Column 3 is folded in through snap_d so the result is ready on the scan's last cycle.
  always_comb begin
    low_cnt = '0;
    hit_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (!snap_d[i]) begin
        low_cnt = low_cnt + 5'd1;
        hit_idx = 4'(i);
      end
    end
    result = (low_cnt == 5'd1) ? {1'b0, code_of(hit_idx)} : ResNone;
  end

  always_comb begin
    prev_d = prev_q;
    cnt_d  = cnt_q;
    if (scan_end) begin
      prev_d = result;
      if (result != prev_q) begin
        cnt_d = CntW'(1);
      end else if (cnt_q < CntMax) begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    key_code_d = key_code_q;
    valid_d    = 1'b0;
    held_d     = held_q;
    accept     = 1'b0;
    if (scan_end) begin
      unique case (state_q)
        StIdle: begin
          if (result != ResNone) state_d = StPressDb;
        end
        StPressDb: begin
          if (result != prev_q) begin
            state_d = StIdle;
          end else if (cnt_d == CntMax && result != ResNone) begin
            state_d    = StPressed;
            key_code_d = result[3:0];
            valid_d    = 1'b1;
            held_d     = 1'b1;
            accept     = 1'b1;
          end
        end
        StPressed: begin
          if (result != {1'b0, key_code_q}) state_d = StReleaseDb;
        end
        StReleaseDb: begin
          // A different key is ignored here: a new press needs a full release first.
          if (result == {1'b0, key_code_q}) begin
            state_d = StPressed;
          end else if (result == ResNone && cnt_d == CntMax) begin
            state_d = StIdle;
            held_d  = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q      <= '0;
      col_idx_q  <= 2'd0;
      col_q      <= 4'b1110;
      snap_q     <= 16'hFFFF;
      prev_q     <= ResNone;
      cnt_q      <= '0;
      state_q    <= StIdle;
      key_code_q <= 4'h0;
      valid_q    <= 1'b0;
      held_q     <= 1'b0;
    end else begin
      div_q      <= div_d;
      col_idx_q  <= col_idx_d;
      col_q      <= col_d;
      snap_q     <= snap_d;
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      key_code_q <= key_code_d;
      valid_q    <= valid_d;
      held_q     <= held_d;
    end
  end

`ifdef ENTRY_REG_EN
  logic [15:0] entry_q, entry_d;

  always_comb begin
    entry_d = entry_q;
    if (accept) begin
      if (key_code_d <= 4'd9) begin
        entry_d = {entry_q[11:0], key_code_d};
      end else if (key_code_d == 4'hC) begin
        entry_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry = entry_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign entry         = 16'h0000;
`endif

  assign col_out   = col_q;
  assign key_code  = key_code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad model drives rows from col_out,
// expected pulses are queued by the stimulus and popped by a key_valid monitor.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] entry;

  logic [15:0] keys = 16'h0000;
  logic [15:0] entry_model = 16'h0000;
  logic [19:0] exp_q[$];
  logic [19:0] mon_e;
  int          n_checks = 0;
  int          n_fail = 0;

  keypad_scanner #(
    .SCAN_DIV      (4),
    .DEBOUNCE_SCANS(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row_in   (row_in),
    .col_out  (col_out),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held),
    .entry    (entry)
  );

  always #5 clk = ~clk;

  // Pressed key at (r,c) pulls row r low while column c is strobed.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
      end
    end
  end

  function automatic logic [15:0] km(input int r, input int c);
    logic [15:0] one;
    one = 16'h0001;
    return one << (r * 4 + c);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: key_code 0x%0h, expected no pulse", key_code);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_code", 32'(key_code), 32'(mon_e[19:16]));
        check("pulse_entry", 32'(entry), 32'(mon_e[15:0]));
      end
    end
  end

  task automatic next_scan_start();
    int n;
    n = 0;
    while (col_out == 4'b1110 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    while (col_out != 4'b1110 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 40) begin
      n_checks++;
      n_fail++;
      $display("FAIL scan_timeout: col_out 0x%0h, expected return to 0xe within 40 cycles",
               col_out);
    end
  endtask

  task automatic wait_scans(input int n);
    for (int i = 0; i < n; i++) next_scan_start();
  endtask

  task automatic model_press(input logic [3:0] code);
`ifdef ENTRY_REG_EN
    if (code <= 4'd9) entry_model = {entry_model[11:0], code};
    else if (code == 4'hC) entry_model = 16'h0000;
`endif
    exp_q.push_back({code, entry_model});
  endtask

  task automatic press_expect(input logic [15:0] mask, input logic [3:0] code,
                              input string name);
    next_scan_start();
    keys = mask;
    model_press(code);
    wait_scans(2);
    check({name, "_held_early"}, 32'(key_held), 32'd0);
    next_scan_start();
    check({name, "_valid"}, 32'(key_valid), 32'd1);
    check({name, "_code"}, 32'(key_code), 32'(code));
    check({name, "_held"}, 32'(key_held), 32'd1);
    @(posedge clk);
    #1;
    check({name, "_valid_one_cycle"}, 32'(key_valid), 32'd0);
  endtask

  task automatic release_keys(input string name);
    next_scan_start();
    keys = 16'h0000;
    wait_scans(2);
    check({name, "_held_during_release"}, 32'(key_held), 32'd1);
    next_scan_start();
    check({name, "_held_released"}, 32'(key_held), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  seq_code[7];
    logic [15:0] seq_mask[7];

    #2;
    rst = 1'b0;
    #1;
    check("rst_col_out", 32'(col_out), 32'h0000000E);
    check("rst_key_valid", 32'(key_valid), 32'd0);
    check("rst_key_held", 32'(key_held), 32'd0);
    check("rst_key_code", 32'(key_code), 32'd0);
    check("rst_entry", 32'(entry), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Key 8 press and release.
    press_expect(km(2, 1), 4'h8, "key8");
    release_keys("key8");

    // Bounce on key 5, then a steady press.
    for (int i = 0; i < 10; i++) begin
      next_scan_start();
      keys = (i % 2 == 0) ? km(1, 1) : 16'h0000;
    end
    next_scan_start();
    check("bounce_no_held", 32'(key_held), 32'd0);
    press_expect(km(1, 1), 4'h5, "key5");
    release_keys("key5");

    // Ghosting: keys 1 and 6 together give nothing; dropping 6 leaves key 1.
    next_scan_start();
    keys = km(0, 0) | km(1, 2);
    wait_scans(5);
    check("ghost_no_held", 32'(key_held), 32'd0);
    press_expect(km(0, 0), 4'h1, "ghost_key1");
    release_keys("ghost_key1");

    // Slide from 9 to 4 without release: no new key until a full release.
    press_expect(km(2, 2), 4'h9, "key9");
    next_scan_start();
    keys = km(1, 0);
    wait_scans(5);
    check("slide_code_kept", 32'(key_code), 32'h9);
    check("slide_still_held", 32'(key_held), 32'd1);
    release_keys("slide");
    press_expect(km(1, 0), 4'h4, "key4");
    release_keys("key4");

    // Entry sequence 1,2,A,3,4,5 then C.
    seq_code = '{4'h1, 4'h2, 4'hA, 4'h3, 4'h4, 4'h5, 4'hC};
    seq_mask = '{km(0, 0), km(0, 1), km(0, 3), km(0, 2), km(1, 0), km(1, 1), km(2, 3)};
    for (int i = 0; i < 7; i++) begin
      press_expect(seq_mask[i], seq_code[i], "entry_seq");
      release_keys("entry_seq");
      if (i == 5) check("entry_2345", 32'(entry), 32'(entry_model));
    end
    check("entry_cleared", 32'(entry), 32'(entry_model));

    // Async reset while key 7 is held, then a fresh pulse from IDLE.
    press_expect(km(2, 0), 4'h7, "key7");
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("midrst_col_out", 32'(col_out), 32'h0000000E);
    check("midrst_key_valid", 32'(key_valid), 32'd0);
    check("midrst_key_held", 32'(key_held), 32'd0);
    check("midrst_key_code", 32'(key_code), 32'd0);
    check("midrst_entry", 32'(entry), 32'd0);
    entry_model = 16'h0000;
    @(negedge clk);
    rst = 1'b1;
    model_press(4'h7);
    repeat (48) @(posedge clk);
    #1;
    check("rerun_valid", 32'(key_valid), 32'd1);
    check("rerun_held", 32'(key_held), 32'd1);
    check("rerun_code", 32'(key_code), 32'h7);
    release_keys("key7_rerun");

    wait_scans(2);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
